// File: rtl/i2c_target_read_if.sv
// Initiator-facing signals of the I2C read target.
// SDA is not in here: it is a plain open-drain port on the block.
`timescale 1ns/1ps
interface i2c_target_read_if;
    logic        SCL;
    logic [15:0] din;
    logic        busy;
    logic        addr_hit;
    logic        done;

    modport master (output SCL, output din, input busy, input addr_hit, input done);
    modport slave  (input SCL, input din, output busy, output addr_hit, output done);
endinterface

// File: rtl/i2c_target_read.sv
// I2C target that answers a read at ADDR with one 16-bit word, MSB byte first.
// SDA is open-drain: the block only ever pulls it low or releases it.
`timescale 1ns/1ps
module i2c_target_read #(
    parameter logic [6:0] ADDR = 7'b1010001
) (
    input  logic             clk,
    input  logic             reset,
    inout  wire              SDA,
    i2c_target_read_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR, ST_ACK_ADDR, ST_TX, ST_MACK, ST_IGNORE
    } state_t;

    logic        scl_p0, scl_p1, scl_p2;
    logic        sda_p0, sda_p1, sda_p2;
    logic        scl_rise, scl_fall, start_c, stop_c;

    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic        byte_cnt_q, byte_cnt_d;
    logic [6:0]  addr_sr_q, addr_sr_d;
    logic [15:0] shreg_q, shreg_d;
    logic        sda_low_q, sda_low_d;
    logic        busy_q, busy_d;
    logic        hit_q, hit_d;
    logic        done_q, done_d;
    logic [7:0]  addr_byte;

    // Pins -> two-flop synchronizer (_p0/_p1), _p2 holds the previous value for edges
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_p0 <= 1'b1; scl_p1 <= 1'b1; scl_p2 <= 1'b1;
            sda_p0 <= 1'b1; sda_p1 <= 1'b1; sda_p2 <= 1'b1;
        end else begin
            scl_p0 <= bus.SCL; scl_p1 <= scl_p0; scl_p2 <= scl_p1;
            sda_p0 <= SDA;     sda_p1 <= sda_p0; sda_p2 <= sda_p1;
        end
    end

    assign scl_rise = scl_p1 & ~scl_p2;
    assign scl_fall = ~scl_p1 & scl_p2;
    assign start_c  = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
    assign stop_c   = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        addr_sr_d  = addr_sr_q;
        shreg_d    = shreg_q;
        sda_low_d  = sda_low_q;
        busy_d     = busy_q;
        hit_d      = 1'b0;
        done_d     = 1'b0;
        addr_byte  = {addr_sr_q, sda_p1};

        if (start_c) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 4'd0;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
        end else if (stop_c) begin
            state_d   = ST_IDLE;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
        end else begin
            unique case (state_q)
                ST_ADDR: if (scl_rise) begin
                    addr_sr_d = addr_byte[6:0];
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d = 4'd0;
                        if (addr_byte == {ADDR, 1'b1}) begin
                            shreg_d    = bus.din;
                            hit_d      = 1'b1;
                            busy_d     = 1'b1;
                            byte_cnt_d = 1'b0;
                            state_d    = ST_ACK_ADDR;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                // First fall starts the ACK; the second ends it and puts out data bit 7
                ST_ACK_ADDR: if (scl_fall) begin
                    if (bit_cnt_q == 4'd0) begin
                        sda_low_d = 1'b1;
                        bit_cnt_d = 4'd1;
                    end else begin
                        sda_low_d = ~shreg_q[15];
                        shreg_d   = {shreg_q[14:0], 1'b0};
                        bit_cnt_d = 4'd1;
                        state_d   = ST_TX;
                    end
                end
                ST_TX: if (scl_fall) begin
                    if (bit_cnt_q == 4'd8) begin
                        sda_low_d = 1'b0;
                        bit_cnt_d = 4'd0;
                        done_d    = byte_cnt_q;
                        state_d   = ST_MACK;
                    end else begin
                        sda_low_d = ~shreg_q[15];
                        shreg_d   = {shreg_q[14:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                ST_MACK: if (scl_rise) begin
                    if (!sda_p1 && !byte_cnt_q) begin
                        byte_cnt_d = 1'b1;
                        state_d    = ST_TX;
                    end else begin
                        state_d = ST_IGNORE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Control and shift state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 4'd0;
            byte_cnt_q <= 1'b0;
            addr_sr_q  <= 7'd0;
            shreg_q    <= 16'd0;
            sda_low_q  <= 1'b0;
            busy_q     <= 1'b0;
            hit_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            addr_sr_q  <= addr_sr_d;
            shreg_q    <= shreg_d;
            sda_low_q  <= sda_low_d;
            busy_q     <= busy_d;
            hit_q      <= hit_d;
            done_q     <= done_d;
        end
    end

    // Gating with reset lets the bus go free without waiting on the flop
    assign SDA          = (sda_low_q && !reset) ? 1'b0 : 1'bz;
    assign bus.busy     = busy_q;
    assign bus.addr_hit = hit_q;
    assign bus.done     = done_q;
endmodule
